chrono_display: RTL



---
 rtl/chrono_pkg.sv | 38 +++
 rtl/chrono_display_seg7_decode.sv | 28 ++
 rtl/chrono_display.sv | 104 ++++++++++
 3 files changed

// File: rtl/chrono_pkg.sv
// Shared constants for the chronometer display path.
// Digit indices, segment codes and the snapshot bundle.
package chrono_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] idx_t;

    localparam idx_t D_SEC1 = 3'd0;
    localparam idx_t D_SEC10 = 3'd1;
    localparam idx_t D_MIN1 = 3'd2;
    localparam idx_t D_MIN10 = 3'd3;
    localparam idx_t D_HS1 = 3'd4;
    localparam idx_t D_HS10 = 3'd5;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Decimal point lit after minutes-ones and hours-ones: HH.MM.SS
    localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;

    typedef struct packed {
        logic [5:0] hs;
        logic [5:0] min;
        logic [5:0] sec;
    } snap_t;

endpackage

// File: rtl/chrono_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern.
// Codes 10..15 turn the digit dark.
module seg7_decode
    import chrono_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup, no state
    always_comb begin
        seg_o = SEG_OFF;
        unique case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/chrono_display.sv
// Six-digit multiplexed HH.MM.SS driver for a common-anode display.
// Inputs are captured once per scan frame to avoid torn frames.
module chrono_display
    import chrono_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [5:0] hs,
    input  logic       blank,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    idx_t             idx_q, idx_d;
    snap_t            snap_q, snap_d;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic [5:0] val;
    logic [3:0] digit;
    logic [6:0] seg_code;
    logic [5:0] onehot;

    // Prescaler, digit index and frame snapshot
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d = idx_q;
        snap_d = snap_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (idx_q == D_HS10) begin
                idx_d = D_SEC1;
                snap_d = '{hs: hs, min: min, sec: sec};
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    // Select the field and split it into tens/ones
    always_comb begin
        val = snap_q.sec;
        unique case (idx_q)
            D_SEC1, D_SEC10: val = snap_q.sec;
            D_MIN1, D_MIN10: val = snap_q.min;
            D_HS1, D_HS10:   val = snap_q.hs;
            default:         val = snap_q.sec;
        endcase
        if (idx_q[0]) digit = 4'(val / 6'd10);
        else digit = 4'(val % 6'd10);
    end

    seg7_decode u_dec (
        .bcd_i (digit),
        .seg_o (seg_code)
    );

    // Next output pattern for the current digit, or dark when blanked
    always_comb begin
        onehot = 6'b000001 << idx_q;
        an_d = ~onehot;
        seg_d = seg_code;
        dp_d = ~|(onehot & DP_MASK);
        if (blank) begin
            an_d = '1;
            seg_d = SEG_OFF;
            dp_d = 1'b1;
        end
    end

    // State and registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q <= D_SEC1;
            snap_q <= '0;
            an_q <= '1;
            seg_q <= SEG_OFF;
            dp_q <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q <= idx_d;
            snap_q <= snap_d;
            an_q <= an_d;
            seg_q <= seg_d;
            dp_q <= dp_d;
        end
    end

    assign an = an_q;
    assign seg = seg_q;
    assign dp = dp_q;

endmodule
